// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer bundle: retire handshake and operands in, fetch PC,
// condition codes and one-cycle status pulses out.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              stall;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] base_val;
    logic              cc_we;
    logic [ADDR_W-1:0] cc_data;

    logic [ADDR_W-1:0] pc;
    logic [2:0]        nzp;
    logic              taken;
    logic              link_we;
    logic [ADDR_W-1:0] link_addr;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output instr_valid, stall, instr, base_val, cc_we, cc_data,
        input  pc, nzp, taken, link_we, link_addr, ras_ovf, ras_unf
    );

    modport slave (
        input  instr_valid, stall, instr, base_val, cc_we, cc_data,
        output pc, nzp, taken, link_we, link_addr, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// LC-3 program counter and branch unit: holds PC and NZP, resolves BR/JMP/RET/JSR/JSRR,
// and keeps an optional circular return-address stack for RET prediction.
module pc_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h3000,
    parameter int                RAS_DEPTH = 4,
    parameter bit                USE_RAS   = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
    localparam int         PTR_W  = $clog2(RAS_DEPTH);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] link_addr_q;
    logic [2:0]        nzp_q;
    logic              taken_q;
    logic              link_we_q;
    logic              ras_ovf_q;
    logic              ras_unf_q;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wp;
    logic [PTR_W:0]    ras_cnt;

    logic              retire;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jsr_off;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              cond;
    logic              is_ret;
    logic              cc_n;
    logic              cc_z;
    logic              cc_p;

    logic [ADDR_W-1:0] pc_next;
    logic              taken_next;
    logic              link_we_next;
    logic              unf_next;
    logic              push;
    logic              pop;

    assign retire    = bus.instr_valid & ~bus.stall;
    assign opcode    = bus.instr[15:12];
    assign inc       = pc_q + ADDR_W'(1);
    assign br_off    = {{(ADDR_W-9){bus.instr[8]}}, bus.instr[8:0]};
    assign jsr_off   = {{(ADDR_W-11){bus.instr[10]}}, bus.instr[10:0]};
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == (PTR_W+1)'(RAS_DEPTH));
    // ras_wp points at the next free slot, so the newest entry sits just below it.
    assign ras_top   = ras_mem[ras_wp - PTR_W'(1)];
    assign cond      = |(bus.instr[11:9] & nzp_q);
    assign is_ret    = USE_RAS && (bus.instr[8:6] == 3'd7);

    assign cc_n = bus.cc_data[ADDR_W-1];
    assign cc_z = (bus.cc_data == '0);
    assign cc_p = ~cc_n & ~cc_z;

    always_comb begin
        pc_next      = inc;
        taken_next   = 1'b0;
        link_we_next = 1'b0;
        unf_next     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (opcode)
            OP_BR: begin
                if (cond) begin
                    pc_next    = inc + br_off;
                    taken_next = 1'b1;
                end
            end
            OP_JMP: begin
                taken_next = 1'b1;
                if (is_ret && !ras_empty) begin
                    pc_next = ras_top;
                    pop     = 1'b1;
                end else begin
                    pc_next  = bus.base_val;
                    unf_next = is_ret;
                end
            end
            OP_JSR: begin
                taken_next   = 1'b1;
                link_we_next = 1'b1;
                push         = USE_RAS;
                pc_next      = bus.instr[11] ? (inc + jsr_off) : bus.base_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            nzp_q       <= 3'b010;
            ras_wp      <= '0;
            ras_cnt     <= '0;
            taken_q     <= 1'b0;
            link_we_q   <= 1'b0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
            link_addr_q <= '0;
        end else begin
            // Condition codes load regardless of retire; a same-cycle BR already saw the old nzp_q.
            if (bus.cc_we) begin
                nzp_q <= {cc_n, cc_z, cc_p};
            end
            taken_q   <= retire & taken_next;
            link_we_q <= retire & link_we_next;
            ras_ovf_q <= retire & push & ras_full;
            ras_unf_q <= retire & unf_next;
            if (retire) begin
                pc_q <= pc_next;
                if (link_we_next) begin
                    link_addr_q <= inc;
                end
                if (push) begin
                    ras_wp <= ras_wp + PTR_W'(1);
                    if (!ras_full) begin
                        ras_cnt <= ras_cnt + (PTR_W+1)'(1);
                    end
                end else if (pop) begin
                    ras_wp  <= ras_wp - PTR_W'(1);
                    ras_cnt <= ras_cnt - (PTR_W+1)'(1);
                end
            end
        end
    end

    // When full, ras_wp also addresses the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (rst_n && retire && push) begin
            ras_mem[ras_wp] <= inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.nzp       = nzp_q;
    assign bus.taken     = taken_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_addr = link_addr_q;
    assign bus.ras_ovf   = ras_ovf_q;
    assign bus.ras_unf   = ras_unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run, all checked
// against a queue-based behavioural model of PC, NZP and the return stack.
module tb_pc_sequencer;
    localparam int RAS_D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    pc_sequencer_if #(.ADDR_W(16)) bus ();

    pc_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h3000),
        .RAS_DEPTH(RAS_D),
        .USE_RAS  (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] m_pc;
    logic [2:0]  m_nzp;
    logic        m_taken, m_link_we, m_ovf, m_unf;
    logic [15:0] m_link_addr;
    logic [15:0] m_ras[$];

    task automatic model_reset();
        m_pc = 16'h3000;
        m_nzp = 3'b010;
        m_taken = 0; m_link_we = 0; m_ovf = 0; m_unf = 0;
        m_link_addr = 16'h0000;
        m_ras.delete();
    endtask

    task automatic model_step(input logic v, input logic st, input logic [15:0] ins,
                              input logic [15:0] base, input logic ccwe, input logic [15:0] ccd);
        int inc, off;
        bit brc;
        m_taken = 0; m_link_we = 0; m_ovf = 0; m_unf = 0;
        if (v && !st) begin
            inc = (int'(m_pc) + 1) % 65536;
            case (ins[15:12])
                4'b0000: begin
                    brc = (ins[11] && m_nzp[2]) || (ins[10] && m_nzp[1]) || (ins[9] && m_nzp[0]);
                    off = int'(ins[8:0]);
                    if (ins[8]) off -= 512;
                    if (brc) begin m_pc = 16'(inc + off); m_taken = 1; end
                    else m_pc = 16'(inc);
                end
                4'b1100: begin
                    m_taken = 1;
                    if (ins[8:6] == 3'd7 && m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc = base;
                        if (ins[8:6] == 3'd7) m_unf = 1;
                    end
                end
                4'b0100: begin
                    m_taken = 1; m_link_we = 1; m_link_addr = 16'(inc);
                    if (m_ras.size() == RAS_D) begin void'(m_ras.pop_front()); m_ovf = 1; end
                    m_ras.push_back(16'(inc));
                    off = int'(ins[10:0]);
                    if (ins[10]) off -= 2048;
                    m_pc = ins[11] ? 16'(inc + off) : base;
                end
                default: m_pc = 16'(inc);
            endcase
        end
        if (ccwe) m_nzp = (ccd == 0) ? 3'b010 : (ccd[15] ? 3'b100 : 3'b001);
    endtask

    task automatic do_cycle(input logic v, input logic st, input logic [15:0] ins,
                            input logic [15:0] base, input logic ccwe, input logic [15:0] ccd);
        bus.instr_valid = v; bus.stall = st; bus.instr = ins;
        bus.base_val = base; bus.cc_we = ccwe; bus.cc_data = ccd;
        model_step(v, st, ins, base, ccwe, ccd);
        @(posedge clk);
        #1;
        bus.instr_valid = 0; bus.stall = 0; bus.cc_we = 0;
    endtask

    task automatic hold_reset(input logic [15:0] ins);
        rst_n = 0;
        bus.instr_valid = 1; bus.stall = 0; bus.instr = ins;
        bus.base_val = 16'h1234; bus.cc_we = 1; bus.cc_data = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        bus.instr_valid = 0; bus.cc_we = 0;
        model_reset();
    endtask

    task automatic test_reset();
        hold_reset(16'h4810);
        n_total++;
        if (bus.pc !== 16'h3000) $display("FAIL reset_pc: got %h want 3000", bus.pc); else n_pass++;
        n_total++;
        if (bus.nzp !== 3'b010) $display("FAIL reset_nzp: got %b want 010", bus.nzp); else n_pass++;
        n_total++;
        if ({bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000",
                     {bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf});
        else n_pass++;
        n_total++;
        if (bus.link_addr !== 16'h0000) $display("FAIL reset_link: got %h want 0000", bus.link_addr); else n_pass++;
        repeat (3) do_cycle(0, 0, 16'h1000, 16'h0, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3000 || bus.nzp !== 3'b010)
            $display("FAIL idle_hold: got pc=%h nzp=%b want pc=3000 nzp=010", bus.pc, bus.nzp);
        else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1, 0, 16'h1000, 16'h0, 0, 16'h0);
            n_total++;
            if (bus.pc !== 16'h3000 + 16'(i) || bus.taken !== 1'b0)
                $display("FAIL seq_add%0d: got pc=%h taken=%b want pc=%h taken=0",
                         i, bus.pc, bus.taken, 16'h3000 + 16'(i));
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        do_cycle(0, 0, 16'h0000, 16'h0, 1, 16'hFFFF);
        n_total++;
        if (bus.nzp !== 3'b100) $display("FAIL cc_neg: got %b want 100", bus.nzp); else n_pass++;
        do_cycle(1, 0, 16'hC080, 16'h3010, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3010 || bus.taken !== 1'b1)
            $display("FAIL jmp: got pc=%h taken=%b want pc=3010 taken=1", bus.pc, bus.taken);
        else n_pass++;
        do_cycle(1, 0, 16'h09FE, 16'h0, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h300F || bus.taken !== 1'b1)
            $display("FAIL brn_back: got pc=%h taken=%b want pc=300f taken=1", bus.pc, bus.taken);
        else n_pass++;
        do_cycle(1, 0, 16'h0405, 16'h0, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3010 || bus.taken !== 1'b0)
            $display("FAIL brz_not: got pc=%h taken=%b want pc=3010 taken=0", bus.pc, bus.taken);
        else n_pass++;
    endtask

    task automatic test_cc_same_edge();
        do_cycle(1, 0, 16'h0404, 16'h0, 1, 16'h0000);
        n_total++;
        if (bus.pc !== 16'h3011 || bus.taken !== 1'b0)
            $display("FAIL cc_same_edge_br: got pc=%h taken=%b want pc=3011 taken=0", bus.pc, bus.taken);
        else n_pass++;
        n_total++;
        if (bus.nzp !== 3'b010) $display("FAIL cc_same_edge_nzp: got %b want 010", bus.nzp); else n_pass++;
    endtask

    task automatic test_jsr_ret();
        do_cycle(1, 0, 16'hC080, 16'h3020, 0, 16'h0);
        do_cycle(1, 0, 16'h4810, 16'h0, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3031 || bus.link_we !== 1'b1 || bus.link_addr !== 16'h3021)
            $display("FAIL jsr: got pc=%h link_we=%b link=%h want pc=3031 link_we=1 link=3021",
                     bus.pc, bus.link_we, bus.link_addr);
        else n_pass++;
        do_cycle(1, 0, 16'hC1C0, 16'h0000, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3021 || bus.ras_unf !== 1'b0 || bus.link_we !== 1'b0)
            $display("FAIL ret_ras: got pc=%h unf=%b link_we=%b want pc=3021 unf=0 link_we=0",
                     bus.pc, bus.ras_unf, bus.link_we);
        else n_pass++;
        do_cycle(1, 0, 16'hC080, 16'h3040, 0, 16'h0);
        do_cycle(1, 0, 16'h4100, 16'h5000, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h5000 || bus.link_addr !== 16'h3041 || bus.link_we !== 1'b1)
            $display("FAIL jsrr: got pc=%h link=%h link_we=%b want pc=5000 link=3041 link_we=1",
                     bus.pc, bus.link_addr, bus.link_we);
        else n_pass++;
        do_cycle(1, 0, 16'hC1C0, 16'h0000, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h3041) $display("FAIL jsrr_ret: got %h want 3041", bus.pc); else n_pass++;
    endtask

    task automatic test_ras_overflow();
        logic [15:0] want;
        do_cycle(1, 0, 16'hC080, 16'h3100, 0, 16'h0);
        for (int i = 1; i <= 5; i++) begin
            do_cycle(1, 0, 16'h4800, 16'h0, 0, 16'h0);
            n_total++;
            if (bus.pc !== 16'h3100 + 16'(i) || bus.ras_ovf !== (i == 5))
                $display("FAIL ras_push%0d: got pc=%h ovf=%b want pc=%h ovf=%b",
                         i, bus.pc, bus.ras_ovf, 16'h3100 + 16'(i), (i == 5));
            else n_pass++;
        end
        for (int i = 1; i <= 5; i++) begin
            do_cycle(1, 0, 16'hC1C0, 16'h4000, 0, 16'h0);
            want = (i == 5) ? 16'h4000 : 16'h3106 - 16'(i);
            n_total++;
            if (bus.pc !== want || bus.ras_unf !== (i == 5) || bus.taken !== 1'b1)
                $display("FAIL ras_pop%0d: got pc=%h unf=%b taken=%b want pc=%h unf=%b taken=1",
                         i, bus.pc, bus.ras_unf, bus.taken, want, (i == 5));
            else n_pass++;
        end
    endtask

    task automatic test_wrap_stall();
        do_cycle(1, 0, 16'hC080, 16'hFFFF, 0, 16'h0);
        do_cycle(1, 0, 16'h0E01, 16'h0, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h0001 || bus.taken !== 1'b1)
            $display("FAIL wrap: got pc=%h taken=%b want pc=0001 taken=1", bus.pc, bus.taken);
        else n_pass++;
        do_cycle(1, 1, 16'h4810, 16'h2222, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h0001 || {bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf} !== 4'b0000)
            $display("FAIL stall: got pc=%h pulses=%b want pc=0001 pulses=0000",
                     bus.pc, {bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_cycle(1, 0, 16'h4800, 16'h0, 0, 16'h0);
        do_cycle(1, 0, 16'h4800, 16'h0, 0, 16'h0);
        hold_reset(16'hC1C0);
        n_total++;
        if (bus.pc !== 16'h3000 || bus.nzp !== 3'b010 || bus.taken !== 1'b0)
            $display("FAIL reset_mid: got pc=%h nzp=%b taken=%b want pc=3000 nzp=010 taken=0",
                     bus.pc, bus.nzp, bus.taken);
        else n_pass++;
        do_cycle(1, 0, 16'hC1C0, 16'h5555, 0, 16'h0);
        n_total++;
        if (bus.pc !== 16'h5555 || bus.ras_unf !== 1'b1)
            $display("FAIL reset_ras_clear: got pc=%h unf=%b want pc=5555 unf=1", bus.pc, bus.ras_unf);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] ins, ccd;
        logic        v, st, ccwe;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0, 1: ins = {4'b0000, 12'($urandom)};
                2:    ins = {7'b1100000, 3'($urandom_range(0, 6)), 6'b0};
                3:    ins = 16'hC1C0;
                4:    ins = {5'b01001, 11'($urandom)};
                5:    ins = {7'b0100000, 3'($urandom), 6'b0};
                default: ins = 16'($urandom);
            endcase
            v    = ($urandom_range(0, 9) < 8);
            st   = ($urandom_range(0, 9) < 2);
            ccwe = ($urandom_range(0, 9) < 3);
            ccd  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            do_cycle(v, st, ins, 16'($urandom), ccwe, ccd);
            n_total++;
            if ({bus.pc, bus.nzp, bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf} !==
                {m_pc, m_nzp, m_taken, m_link_we, m_ovf, m_unf})
                $display("FAIL rand%0d: got pc=%h nzp=%b t/l/o/u=%b want pc=%h nzp=%b t/l/o/u=%b", n,
                         bus.pc, bus.nzp, {bus.taken, bus.link_we, bus.ras_ovf, bus.ras_unf},
                         m_pc, m_nzp, {m_taken, m_link_we, m_ovf, m_unf});
            else n_pass++;
            if (m_link_we) begin
                n_total++;
                if (bus.link_addr !== m_link_addr)
                    $display("FAIL rand_link%0d: got %h want %h", n, bus.link_addr, m_link_addr);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.instr_valid = 0; bus.stall = 0; bus.instr = 16'h0;
        bus.base_val = 16'h0; bus.cc_we = 0; bus.cc_data = 16'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_cc_same_edge();
        test_jsr_ret();
        test_ras_overflow();
        test_wrap_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
